cart_bus_arbiter: RTL

- N-master arbiter in front of cart_iface; generalises the fixed two-way startup/SPI ROM-bus mux into a parametrised, handshaked bus.
- Each master issues single-byte read/write requests.
- Arbiter grants one master at a time (round-robin or fixed priority), drives one rd/wr strobe, tracks cart_iface busy, returns data with a per-master ack.
- Includes a busy-timeout error path and a per-master enable mask.

---
 rtl/cart_bus_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cart_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cart_bus_arbiter
// Purpose  : N-master arbiter in front of cart_iface. Each master issues
//            single-byte read/write requests. One master at a time is granted
//            (round-robin or fixed priority). The arbiter drives a single
//            rd/wr strobe, follows cart_iface busy, returns read data and
//            pulses a per-master ack. If busy never rises, a timeout ends the
//            transaction with an error.
// Ports    :
//   clk_8m     in   system clock
//   rst_n      in   synchronous reset, active-low
//   m_en       in   [N]        per-master enable mask (0 = requests ignored)
//   m_rd/m_wr  in   [N]        level read/write requests, held until m_ack
//   m_addr     in   [N*ADDR_W] flattened addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_wdata    in   [N*DATA_W] flattened write data
//   m_rdata    out  [DATA_W]   read data, valid with m_ack, held until next read
//   m_ack      out  [N]        one-hot, one-cycle completion pulse
//   m_err      out             one-cycle timeout flag, coincident with m_ack
//   grant      out  [N]        one-hot current owner, 0 when idle
//   bus_rd     out             one-cycle read strobe to cart_iface
//   bus_wr     out             one-cycle write strobe to cart_iface
//   bus_addr   out  [ADDR_W]   latched address, held from ISSUE until ACK
//   bus_din    out  [DATA_W]   latched write data, held from ISSUE until ACK
//   bus_dout   in   [DATA_W]   read data from cart_iface
//   bus_busy   in              cart_iface busy
// Revision : 1.0  initial release
// ============================================================================
module cart_bus_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int RR_MODE      = 1,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                          clk_8m,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_en,
  input  logic [NUM_MASTERS-1:0]        m_rd,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          bus_rd,
  output logic                          bus_wr,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_din,
  input  logic [DATA_W-1:0]             bus_dout,
  input  logic                          bus_busy
);

  localparam int                 C_IDX_W   = $clog2(NUM_MASTERS);
  localparam logic [C_IDX_W-1:0] C_PTR_RST = C_IDX_W'(NUM_MASTERS - 1);
  localparam logic [7:0]         C_TIMEOUT = 8'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ACK       = 3'd4
  } state_t;

  state_t              r_state;
  logic [C_IDX_W-1:0]  r_ptr;
  logic [7:0]          r_cnt;
  logic                r_op_wr;

  logic [NUM_MASTERS-1:0] w_active;
  logic [NUM_MASTERS-1:0] w_above_ptr;
  logic [NUM_MASTERS-1:0] w_rr_sel;
  logic [NUM_MASTERS-1:0] w_cand;
  logic                   w_found;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [C_IDX_W-1:0]     w_win_idx;
  logic                   w_win_wr;
  logic [ADDR_W-1:0]      w_win_addr;
  logic [DATA_W-1:0]      w_win_wdata;
  logic [7:0]             w_cnt_nxt;

  assign w_active  = m_en & (m_rd | m_wr);
  assign w_cnt_nxt = r_cnt + 8'd1;

  // Round-robin is done as a two-level priority: masters above the pointer
  // take precedence; if none of them is active, fall back to the lowest
  // active index (the wrap-around). Fixed priority uses the fallback only.
  always_comb begin
    w_above_ptr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_above_ptr[i] = (RR_MODE != 0) && (i > int'(r_ptr));
    end
  end

  assign w_rr_sel = w_active & w_above_ptr;
  assign w_cand   = (|w_rr_sel) ? w_rr_sel : w_active;
  assign w_found  = |w_cand;

  // Lowest-index pick among candidates; iterating downward lets the lowest
  // index overwrite any higher one.
  always_comb begin
    w_win_oh    = '0;
    w_win_idx   = '0;
    w_win_wr    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_idx   = C_IDX_W'(i);
        w_win_wr    = m_wr[i];   // rd and wr both high counts as a write
        w_win_addr  = m_addr[i*ADDR_W +: ADDR_W];
        w_win_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= C_PTR_RST;   // master 0 gets first priority after reset
      r_cnt    <= 8'd0;
      r_op_wr  <= 1'b0;
      grant    <= '0;
      bus_rd   <= 1'b0;
      bus_wr   <= 1'b0;
      bus_addr <= '0;
      bus_din  <= '0;
      m_ack    <= '0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            grant    <= w_win_oh;
            r_ptr    <= w_win_idx;
            r_op_wr  <= w_win_wr;
            bus_addr <= w_win_addr;
            bus_din  <= w_win_wdata;
            bus_rd   <= ~w_win_wr;
            bus_wr   <= w_win_wr;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          bus_rd  <= 1'b0;
          bus_wr  <= 1'b0;
          r_cnt   <= 8'd0;
          r_state <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (bus_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (w_cnt_nxt >= C_TIMEOUT) begin
            // cart_iface never accepted the strobe: finish with an error
            m_ack   <= grant;
            m_err   <= 1'b1;
            if (!r_op_wr) begin
              m_rdata <= '1;
            end
            r_state <= S_ACK;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end

        S_WAIT_DONE: begin
          if (!bus_busy) begin
            m_ack <= grant;
            if (!r_op_wr) begin
              m_rdata <= bus_dout;
            end
            r_state <= S_ACK;
          end
        end

        S_ACK: begin
          // Requests are not sampled here; a still-held request is seen
          // as a new one in the following IDLE cycle.
          m_ack    <= '0;
          m_err    <= 1'b0;
          grant    <= '0;
          bus_addr <= '0;
          bus_din  <= '0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
